vga_rx_monitor: RTL

TinyQV peripheral that receives a VGA-style stream on ui_in, using the same pinout our sprite engine drives on uo_out: {vsync, hsync, B[1:0], G[1:0], R[1:0]}, syncs active-high.
- Measures line/frame timing and declares lock.
- Samples one pixel at a programmable raw position.
- Counts lit pixels per frame.
- Raises frame/lock interrupts.
Used for loopback self-test of the display path and for capturing external video timing.

---
 rtl/vga_rx_monitor.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/vga_rx_monitor.sv
// vga_rx_monitor: TinyQV peripheral that watches a VGA-style stream on ui_in
// ({vsync, hsync, B, G, R}, syncs active-high). It measures line/frame timing,
// tracks lock, captures one probed pixel, counts lit pixels per frame and
// raises frame/lock interrupts.
module vga_rx_monitor #(
   parameter int unsigned HCW = 12,
   parameter int unsigned VCW = 11,
   parameter int unsigned LCW = 20
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  ui_in,
   output logic [7:0]  uo_out,
   input  logic [5:0]  address,
   input  logic [31:0] data_in,
   input  logic [1:0]  data_write_n,
   input  logic [1:0]  data_read_n,
   output logic [31:0] data_out,
   output logic        data_ready,
   output logic        user_interrupt
);

   localparam logic [2:0] StDisabled = 3'd0;
   localparam logic [2:0] StSeek     = 3'd1;
   localparam logic [2:0] StMeasure  = 3'd2;
   localparam logic [2:0] StVerify   = 3'd3;
   localparam logic [2:0] StLocked   = 3'd4;

   localparam logic [5:0] AddrCtrl   = 6'h00;
   localparam logic [5:0] AddrStatus = 6'h04;
   localparam logic [5:0] AddrHtim   = 6'h08;
   localparam logic [5:0] AddrVtim   = 6'h0C;
   localparam logic [5:0] AddrProbe  = 6'h10;
   localparam logic [5:0] AddrPixel  = 6'h14;
   localparam logic [5:0] AddrLit    = 6'h18;

   logic [2:0]       state_q, state_d;
   logic             locked_q, locked_d;
   logic [HCW+VCW-1:0] ref_q, ref_d;
   logic [2:0]       ctrl_q, ctrl_d;
   logic [HCW-1:0]   probe_h_q, probe_h_d;
   logic [VCW-1:0]   probe_v_q, probe_v_d;
   logic             hs_prev_q, vs_prev_q;
   logic [HCW-1:0]   hcnt_q, hcnt_d, h_period_q, h_period_d, h_sync_w_q, h_sync_w_d;
   logic [VCW-1:0]   vcnt_q, vcnt_d, v_lines_q, v_lines_d, v_sync_w_q, v_sync_w_d;
   logic [LCW-1:0]   lcnt_q, lcnt_d, lit_q, lit_d;
   logic [5:0]       pixel_q, pixel_d;
   logic             probe_valid_q, probe_valid_d;
   logic             frame_pend_q, frame_pend_d;
   logic             lock_pend_q, lock_pend_d;
   logic             irq_q, irq_d;

   logic             hs, vs, hs_rise, hs_fall, vs_rise, vs_fall;
   logic [5:0]       rgb;
   logic             rgb_lit, active, wr_en;
   logic             hcnt_sat, vcnt_sat, lcnt_sat;
   logic [HCW-1:0]   h_meas;
   logic [2:0]       w1c;
   logic             unused_bits;

   assign vs      = ui_in[7];
   assign hs      = ui_in[6];
   assign rgb     = ui_in[5:0];
   assign rgb_lit = (rgb != 6'd0);
   assign hs_rise = hs & ~hs_prev_q;
   assign hs_fall = ~hs & hs_prev_q;
   assign vs_rise = vs & ~vs_prev_q;
   assign vs_fall = ~vs & vs_prev_q;
   assign active  = (state_q != StDisabled);

   assign hcnt_sat = (hcnt_q == {HCW{1'b1}});
   assign vcnt_sat = (vcnt_q == {VCW{1'b1}});
   assign lcnt_sat = (lcnt_q == {LCW{1'b1}});
   // hcnt+1, pinned at all-ones so a saturated line never wraps to a short period
   assign h_meas   = hcnt_q + {{(HCW-1){1'b0}}, ~hcnt_sat};

   assign wr_en = (data_write_n != 2'b11);
   assign w1c   = (wr_en && address == AddrStatus) ? data_in[3:1] : 3'b000;

   assign uo_out      = 8'h00;
   assign data_ready  = 1'b1;
   assign user_interrupt = irq_q;
   assign unused_bits = ^{data_read_n, data_in[31:27], data_in[15:12]};

   // Counters and timing measurements; all frozen at 0 / held while disabled
   always_comb begin
      hcnt_d     = hcnt_q;
      vcnt_d     = vcnt_q;
      lcnt_d     = lcnt_q;
      h_period_d = h_period_q;
      h_sync_w_d = h_sync_w_q;
      v_lines_d  = v_lines_q;
      v_sync_w_d = v_sync_w_q;
      lit_d      = lit_q;
      if (!active) begin
         hcnt_d = '0;
         vcnt_d = '0;
         lcnt_d = '0;
      end else begin
         if (hs_rise)        hcnt_d = '0;
         else if (!hcnt_sat) hcnt_d = hcnt_q + 1'b1;
         // vsync rise wins over a coincident hsync increment
         if (vs_rise)                   vcnt_d = '0;
         else if (hs_rise && !vcnt_sat) vcnt_d = vcnt_q + 1'b1;
         // the rise cycle's pixel belongs to the new frame
         if (vs_rise)                   lcnt_d = {{(LCW-1){1'b0}}, rgb_lit};
         else if (rgb_lit && !lcnt_sat) lcnt_d = lcnt_q + 1'b1;
         if (hs_rise) h_period_d = h_meas;
         if (hs_fall) h_sync_w_d = h_meas;
         if (vs_rise) begin
            v_lines_d = vcnt_q;
            lit_d     = lcnt_q;
         end
         if (vs_fall) v_sync_w_d = vcnt_q;
      end
   end

   // Lock tracking: compare each frame's {h_period, v_lines} with the previous one
   always_comb begin
      state_d  = state_q;
      locked_d = locked_q;
      ref_d    = ref_q;
      if (!ctrl_q[0]) begin
         state_d  = StDisabled;
         locked_d = 1'b0;
      end else if (state_q == StDisabled) begin
         state_d = StSeek;
      end else if (hcnt_sat || vcnt_sat) begin
         state_d  = StSeek;
         locked_d = 1'b0;
      end else if (vs_rise) begin
         case (state_q)
            StSeek: state_d = StMeasure;
            StMeasure: begin
               ref_d   = {h_period_d, v_lines_d};
               state_d = StVerify;
            end
            StVerify: begin
               if ({h_period_d, v_lines_d} == ref_q) begin
                  state_d  = StLocked;
                  locked_d = 1'b1;
               end else begin
                  ref_d = {h_period_d, v_lines_d};
               end
            end
            StLocked: begin
               if ({h_period_d, v_lines_d} != ref_q) begin
                  state_d  = StVerify;
                  locked_d = 1'b0;
                  ref_d    = {h_period_d, v_lines_d};
               end
            end
            default: state_d = StSeek;
         endcase
      end
   end

   // Register writes, probe capture, sticky flags (a set beats a same-cycle clear)
   always_comb begin
      ctrl_d    = ctrl_q;
      probe_h_d = probe_h_q;
      probe_v_d = probe_v_q;
      if (wr_en && address == AddrCtrl) ctrl_d = data_in[2:0];
      if (wr_en && address == AddrProbe) begin
         probe_h_d = data_in[HCW-1:0];
         probe_v_d = data_in[16 +: VCW];
      end
      pixel_d       = pixel_q;
      probe_valid_d = probe_valid_q & ~w1c[2];
      if (active && !probe_valid_q && hcnt_q == probe_h_q && vcnt_q == probe_v_q) begin
         pixel_d       = rgb;
         probe_valid_d = 1'b1;
      end
      frame_pend_d = (frame_pend_q & ~w1c[0]) | (active & vs_rise);
      lock_pend_d  = (lock_pend_q & ~w1c[1]) | (locked_d != locked_q);
      irq_d        = (frame_pend_q & ctrl_q[1]) | (lock_pend_q & ctrl_q[2]);
   end

   // Read mux, combinational from address
   always_comb begin
      data_out = 32'h0;
      case (address)
         AddrCtrl:   data_out[2:0] = ctrl_q;
         AddrStatus: data_out[3:0] = {probe_valid_q, lock_pend_q, frame_pend_q, locked_q};
         AddrHtim: begin
            data_out[HCW-1:0]  = h_period_q;
            data_out[16 +: HCW] = h_sync_w_q;
         end
         AddrVtim: begin
            data_out[VCW-1:0]  = v_lines_q;
            data_out[16 +: VCW] = v_sync_w_q;
         end
         AddrProbe: begin
            data_out[HCW-1:0]  = probe_h_q;
            data_out[16 +: VCW] = probe_v_q;
         end
         AddrPixel:  data_out[5:0] = pixel_q;
         AddrLit:    data_out[LCW-1:0] = lit_q;
         default:    data_out = 32'h0;
      endcase
   end

   // State registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StDisabled;  locked_q <= 1'b0;  ref_q <= '0;
         ctrl_q <= '0;  probe_h_q <= '0;  probe_v_q <= '0;
         hs_prev_q <= 1'b0;  vs_prev_q <= 1'b0;
         hcnt_q <= '0;  h_period_q <= '0;  h_sync_w_q <= '0;
         vcnt_q <= '0;  v_lines_q <= '0;  v_sync_w_q <= '0;
         lcnt_q <= '0;  lit_q <= '0;
         pixel_q <= '0;  probe_valid_q <= 1'b0;
         frame_pend_q <= 1'b0;  lock_pend_q <= 1'b0;  irq_q <= 1'b0;
      end else begin
         state_q <= state_d;  locked_q <= locked_d;  ref_q <= ref_d;
         ctrl_q <= ctrl_d;  probe_h_q <= probe_h_d;  probe_v_q <= probe_v_d;
         hs_prev_q <= hs;  vs_prev_q <= vs;
         hcnt_q <= hcnt_d;  h_period_q <= h_period_d;  h_sync_w_q <= h_sync_w_d;
         vcnt_q <= vcnt_d;  v_lines_q <= v_lines_d;  v_sync_w_q <= v_sync_w_d;
         lcnt_q <= lcnt_d;  lit_q <= lit_d;
         pixel_q <= pixel_d;  probe_valid_q <= probe_valid_d;
         frame_pend_q <= frame_pend_d;  lock_pend_q <= lock_pend_d;  irq_q <= irq_d;
      end
   end

endmodule
